// File: rtl/vend_arbiter_pkg.sv
// Shared definitions for the vending-engine arbiter: FSM state encoding,
// coin encodings, credit unit values and counter widths.
package vend_arbiter_pkg;

   // Credit mirror width; credit saturates at PRICE so it never wraps.
   localparam int CREDIT_W = 3;

   // Idle counter width; large enough for the maximum TIMEOUT of 255.
   localparam int IDLE_W = 8;

   // Coin encodings as presented on io_coin.
   localparam logic COIN_5C  = 1'b1;
   localparam logic COIN_10C = 1'b0;

   // Credit units contributed by each coin type (1 unit = 5c).
   localparam logic [CREDIT_W-1:0] UNIT_5C  = 3'd1;
   localparam logic [CREDIT_W-1:0] UNIT_10C = 3'd2;

   // Engine ownership / payment sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FEED   = 3'd1,
      ST_STEP   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_VEND   = 3'd4,
      ST_REFUND = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Credit units for a coin type.
   function automatic logic [CREDIT_W-1:0] coin_units(input logic coin);
      logic [CREDIT_W-1:0] units;
      units = UNIT_5C;
      case (coin)
         COIN_5C:  units = UNIT_5C;
         COIN_10C: units = UNIT_10C;
      endcase
      return units;
   endfunction

endpackage

// File: rtl/vend_arbiter_rr_arbiter.sv
// Round-robin request arbiter: grants the first set request at or after
// the pointer, wrapping around. Purely combinational, one-hot grant.
module rr_arbiter
   import vend_arbiter_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PW-1:0]        ptr,
   output logic [NUM_PORTS-1:0] grant
);

   logic [PW-1:0] idx;
   logic          found;

   // Scan from the pointer position and keep only the first hit.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves a value held over from a previous evaluation (no latch).
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = PW'((int'(ptr) + k) % NUM_PORTS);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vend_arbiter.sv
// Shares one vending engine among NUM_PORTS coin ports. Ownership is
// granted round-robin; the owner's coins are forwarded to the engine one
// at a time while a local credit mirror tracks payment. A full price
// produces a vend, an idle owner is refunded after TIMEOUT cycles.
module vend_arbiter
   import vend_arbiter_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   parameter  int TIMEOUT   = 255,
   parameter  int PRICE     = 4,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] io_req,
   input  logic [NUM_PORTS-1:0] io_coin_valid,
   input  logic [NUM_PORTS-1:0] io_coin,
   output logic [NUM_PORTS-1:0] io_coin_ready,
   output logic                 io_vend_valid,
   input  logic                 io_vend_ready,
   output logic                 io_vend_change,
   output logic                 io_refund_valid,
   output logic [2:0]           io_refund_amt,
   output logic [PW-1:0]        io_port,
   output logic                 io_busy,
   output logic                 eng_step,
   output logic                 eng_coin,
   output logic                 eng_clear,
   input  logic                 eng_valid,
   output logic                 io_err
);

   localparam logic [CREDIT_W-1:0] PRICE_U   = CREDIT_W'(PRICE);
   localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [PW-1:0]       LAST_PORT = PW'(NUM_PORTS - 1);

   state_t                  state;
   state_t                  next_state;
   logic [PW-1:0]           rr_ptr;
   logic [CREDIT_W-1:0]     credit;
   logic [IDLE_W-1:0]       idle_cnt;
   logic                    coin_lat;
   logic                    change_flag;
   logic                    err_flag;

   logic [NUM_PORTS-1:0]    grant;
   logic [PW-1:0]           grant_idx;
   logic                    coin_hs;
   logic [CREDIT_W:0]       credit_sum;
   logic                    credit_sat;
   logic                    overpay;
   logic                    credit_full;
   logic                    owner_req;

   rr_arbiter #(
      .NUM_PORTS(NUM_PORTS)
   ) u_rr_arbiter (
      .req   (io_req),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   // Convert the one-hot grant into the owner index.
   always_comb begin
      grant_idx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (grant[k]) begin
            grant_idx = PW'(k);
         end
      end
   end

   // Only the owner is ever ready, so its valid alone forms the handshake.
   assign coin_hs     = (state == ST_FEED) && io_coin_valid[io_port];
   assign owner_req   = io_req[io_port];
   assign credit_sum  = {1'b0, credit} + {1'b0, coin_units(io_coin[io_port])};
   assign credit_sat  = (credit_sum >= {1'b0, PRICE_U});
   assign overpay     = (credit_sum >  {1'b0, PRICE_U});
   assign credit_full = (credit == PRICE_U);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decision; a handshake wins over release and timeout.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: begin
            if (|grant) begin
               next_state = ST_FEED;
            end
         end
         ST_FEED: begin
            if (coin_hs) begin
               next_state = ST_STEP;
            end else if (!owner_req && (credit == '0)) begin
               next_state = ST_IDLE;
            end else if (idle_cnt == IDLE_LAST) begin
               next_state = ST_REFUND;
            end
         end
         ST_STEP: begin
            next_state = ST_CHECK;
         end
         ST_CHECK: begin
            next_state = credit_full ? ST_VEND : ST_FEED;
         end
         ST_VEND: begin
            if (io_vend_ready) begin
               next_state = ST_DONE;
            end
         end
         ST_REFUND: begin
            next_state = ST_DONE;
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from the current state and owner.
   always_comb begin
      io_coin_ready   = '0;
      io_vend_valid   = 1'b0;
      io_vend_change  = 1'b0;
      io_refund_valid = 1'b0;
      io_refund_amt   = '0;
      eng_step        = 1'b0;
      eng_coin        = 1'b0;
      eng_clear       = 1'b0;
      case (state)
         ST_FEED: begin
            io_coin_ready[io_port] = 1'b1;
         end
         ST_STEP: begin
            eng_step = 1'b1;
            eng_coin = coin_lat;
         end
         ST_VEND: begin
            io_vend_valid  = 1'b1;
            io_vend_change = change_flag;
            eng_step       = io_vend_ready;
         end
         ST_REFUND: begin
            io_refund_valid = 1'b1;
            io_refund_amt   = credit;
            eng_clear       = 1'b1;
         end
         default: ;
      endcase
   end

   assign io_busy = (state != ST_IDLE);
   assign io_err  = err_flag;

   // Ownership, credit mirror, change flag, error flag and rr pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         io_port     <= '0;
         rr_ptr      <= '0;
         credit      <= '0;
         coin_lat    <= 1'b0;
         change_flag <= 1'b0;
         err_flag    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  io_port     <= grant_idx;
                  credit      <= '0;
                  change_flag <= 1'b0;
               end
            end
            ST_FEED: begin
               if (coin_hs) begin
                  coin_lat <= io_coin[io_port];
                  credit   <= credit_sat ? PRICE_U : credit_sum[CREDIT_W-1:0];
                  if (overpay) begin
                     change_flag <= 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               if (eng_valid != credit_full) begin
                  err_flag <= 1'b1;
               end
            end
            ST_VEND: begin
               if (io_vend_ready) begin
                  credit <= '0;
               end
            end
            ST_REFUND: begin
               credit <= '0;
            end
            ST_DONE: begin
               rr_ptr      <= (io_port == LAST_PORT) ? '0 : io_port + PW'(1);
               change_flag <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Idle counter: counts FEED cycles without a handshake, cleared otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt <= '0;
      end else if ((state == ST_FEED) && !coin_hs) begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end else begin
         idle_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed plus randomized bench for vend_arbiter. A transaction-level
// reference (grant pointer, credit, change and error flags) predicts each
// observation; a small engine model drives eng_valid from the DUT steps.
module tb_vend_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;
   localparam int PR = 4;

   logic         clk;
   logic         reset;
   logic [N-1:0] io_req;
   logic [N-1:0] io_coin_valid;
   logic [N-1:0] io_coin;
   logic [N-1:0] io_coin_ready;
   logic         io_vend_valid;
   logic         io_vend_ready;
   logic         io_vend_change;
   logic         io_refund_valid;
   logic [2:0]   io_refund_amt;
   logic [1:0]   io_port;
   logic         io_busy;
   logic         eng_step;
   logic         eng_coin;
   logic         eng_clear;
   logic         eng_valid;
   logic         io_err;

   vend_arbiter #(
      .NUM_PORTS(N),
      .TIMEOUT  (TO),
      .PRICE    (PR)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .io_req         (io_req),
      .io_coin_valid  (io_coin_valid),
      .io_coin        (io_coin),
      .io_coin_ready  (io_coin_ready),
      .io_vend_valid  (io_vend_valid),
      .io_vend_ready  (io_vend_ready),
      .io_vend_change (io_vend_change),
      .io_refund_valid(io_refund_valid),
      .io_refund_amt  (io_refund_amt),
      .io_port        (io_port),
      .io_busy        (io_busy),
      .eng_step       (eng_step),
      .eng_coin       (eng_coin),
      .eng_clear      (eng_clear),
      .eng_valid      (eng_valid),
      .io_err         (io_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine model: accumulates forwarded coins, steps back to empty once full.
   logic [2:0] eng_cred;
   logic       eng_fault;
   int         eng_sum;
   int         step_cnt = 0;

   assign eng_sum   = int'(eng_cred) + (eng_coin ? 1 : 2);
   assign eng_valid = (int'(eng_cred) == PR) ^ eng_fault;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         eng_cred <= 3'd0;
      end else if (eng_clear) begin
         eng_cred <= 3'd0;
      end else if (eng_step) begin
         if (int'(eng_cred) >= PR) eng_cred <= 3'd0;
         else eng_cred <= 3'((eng_sum > PR) ? PR : eng_sum);
      end
   end

   always @(posedge clk) begin
      if (reset && eng_step) step_cnt <= step_cnt + 1;
   end

   // Reference state.
   int n_total = 0;
   int n_pass  = 0;
   int m_ptr;
   int m_owner;
   int m_credit;
   bit m_change;
   bit m_err;
   int order_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int exp_grant(input logic [N-1:0] mask, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Called at a negedge in IDLE; grant is visible one edge later.
   task automatic start_session(input logic [N-1:0] mask);
      int exp;
      exp = exp_grant(mask, m_ptr);
      io_req = mask;
      tick();
      check("grant_busy", io_busy, 1);
      check("grant_port", io_port, exp);
      check("grant_ready", io_coin_ready, 32'd1 << exp);
      m_owner  = exp;
      m_credit = 0;
      m_change = 1'b0;
      order_q.push_back(exp);
   endtask

   // Called at a negedge in FEED; returns at a negedge in FEED or VEND.
   task automatic insert_coin(input logic coin, input int gap);
      int u;
      for (int g = 0; g < gap; g++) begin
         check("feed_wait_ready", io_coin_ready, 32'd1 << m_owner);
         tick();
      end
      io_coin                = N'($urandom);
      io_coin[m_owner]       = coin;
      io_coin_valid          = N'($urandom);
      io_coin_valid[m_owner] = 1'b1;
      check("feed_ready", io_coin_ready, 32'd1 << m_owner);
      tick();
      io_coin_valid = '0;
      u = coin ? 1 : 2;
      if (m_credit + u > PR) m_change = 1'b1;
      m_credit = (m_credit + u > PR) ? PR : m_credit + u;
      check("step_pulse", eng_step, 1);
      check("step_coin", eng_coin, coin);
      check("step_ready", io_coin_ready, 0);
      tick();
      check("check_ready", io_coin_ready, 0);
      check("check_nostep", eng_step, 0);
      if (eng_fault) m_err = 1'b1;
      tick();
      check("err_flag", io_err, m_err);
      if (m_credit == PR) begin
         check("vend_valid", io_vend_valid, 1);
         check("vend_change", io_vend_change, m_change);
         check("vend_noready", io_coin_ready, 0);
      end else begin
         check("no_vend", io_vend_valid, 0);
         check("refeed_ready", io_coin_ready, 32'd1 << m_owner);
      end
   endtask

   task automatic finish_vend(input int hold);
      for (int h = 0; h < hold; h++) begin
         check("bp_vend_held", io_vend_valid, 1);
         check("bp_no_ready", io_coin_ready, 0);
         check("bp_owner", io_port, m_owner);
         check("bp_nostep", eng_step, 0);
         tick();
      end
      io_vend_ready = 1'b1;
      #1;
      check("vend_step", eng_step, 1);
      tick();
      io_vend_ready = 1'b0;
      check("done_busy", io_busy, 1);
      check("done_novend", io_vend_valid, 0);
      m_ptr    = (m_owner + 1) % N;
      m_credit = 0;
      tick();
      check("idle_busy", io_busy, 0);
   endtask

   task automatic timeout_refund();
      for (int i = 0; i < TO; i++) begin
         check("to_wait_ready", io_coin_ready, 32'd1 << m_owner);
         check("to_wait_norefund", io_refund_valid, 0);
         tick();
      end
      check("refund_valid", io_refund_valid, 1);
      check("refund_amt", io_refund_amt, m_credit);
      check("refund_clear", eng_clear, 1);
      check("refund_busy", io_busy, 1);
      tick();
      check("refund_pulse_end", io_refund_valid, 0);
      check("refund_done_busy", io_busy, 1);
      m_ptr    = (m_owner + 1) % N;
      m_credit = 0;
      tick();
      check("refund_idle", io_busy, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, io_coin_ready, 0);
      check({tag, "_vend"}, io_vend_valid, 0);
      check({tag, "_change"}, io_vend_change, 0);
      check({tag, "_refund"}, io_refund_valid, 0);
      check({tag, "_amt"}, io_refund_amt, 0);
      check({tag, "_port"}, io_port, 0);
      check({tag, "_busy"}, io_busy, 0);
      check({tag, "_step"}, eng_step, 0);
      check({tag, "_coin"}, eng_coin, 0);
      check({tag, "_clear"}, eng_clear, 0);
      check({tag, "_err"}, io_err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};
      reset = 1'b0;
      io_req = '0;
      io_coin_valid = '0;
      io_coin = '0;
      io_vend_ready = 1'b0;
      eng_fault = 1'b0;
      m_ptr = 0;
      m_err = 1'b0;
      m_credit = 0;
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b1;
      tick();
      check("post_reset_idle", io_busy, 0);

      // Single buyer on port 0, four 5c coins, five engine steps in total.
      base = step_cnt;
      start_session(4'b0001);
      for (int i = 0; i < 4; i++) insert_coin(1'b1, 0);
      finish_vend(0);
      check("single_steps", step_cnt - base, 5);

      // Overpay on port 2: 10c, 5c, 10c.
      start_session(4'b0100);
      insert_coin(1'b0, 0);
      insert_coin(1'b1, 1);
      insert_coin(1'b0, 0);
      finish_vend(1);

      // Timeout on port 1 after one 10c coin.
      start_session(4'b0010);
      insert_coin(1'b0, 0);
      timeout_refund();

      // Timeout with no credit on port 3: pulse with zero amount.
      start_session(4'b1000);
      timeout_refund();

      // Fairness with every port requesting; first vend held off 10 cycles.
      order_q.delete();
      for (int s = 0; s < 5; s++) begin
         start_session(4'b1111);
         while (m_credit < PR) insert_coin(1'($urandom_range(0, 1)), $urandom_range(0, 2));
         finish_vend((s == 0) ? 10 : $urandom_range(0, 3));
      end
      for (int s = 0; s < 5; s++) check("fair_order", order_q[s], exp_order[s]);

      // Owner releases with zero credit: straight back to IDLE, pointer kept.
      start_session(4'b0100);
      io_req = '0;
      tick();
      check("release_idle", io_busy, 0);

      // Owner drops request mid-payment: ignored, timeout refunds it.
      start_session(4'b0010);
      insert_coin(1'b1, 0);
      io_req = '0;
      timeout_refund();

      // Engine disagreement sets the sticky error flag.
      start_session(4'b1001);
      eng_fault = 1'b1;
      insert_coin(1'b1, 0);
      eng_fault = 1'b0;
      while (m_credit < PR) insert_coin(1'($urandom_range(0, 1)), 0);
      finish_vend(0);
      check("err_sticky", io_err, 1);

      // Randomized sessions.
      for (int s = 0; s < 25; s++) begin
         int ncoin;
         start_session(N'($urandom_range(1, 15)));
         ncoin = $urandom_range(0, 5);
         for (int c = 0; c < ncoin && m_credit < PR; c++) begin
            insert_coin(1'($urandom_range(0, 1)), $urandom_range(0, 3));
         end
         if (m_credit == PR) finish_vend($urandom_range(0, 3));
         else timeout_refund();
      end

      // Asynchronous reset while in STEP.
      start_session(4'b1111);
      io_coin_valid = N'(1) << m_owner;
      io_coin = '1;
      tick();
      io_coin_valid = '0;
      io_req = '0;
      check("pre_reset_step", eng_step, 1);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      tick();
      check("reset_no_refund", io_refund_valid, 0);
      reset = 1'b1;
      m_ptr = 0;
      m_err = 1'b0;
      m_credit = 0;
      tick();
      check("after_reset_idle", io_busy, 0);
      check("after_reset_err", io_err, 0);
      start_session(4'b1111);
      while (m_credit < PR) insert_coin(1'($urandom_range(0, 1)), 0);
      finish_vend(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
